// File: rtl/cu_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit: state codes,
// opcodes, ALU operation codes, mux-select encodings, trap causes and the
// ALU operation decode helper.
package cu_pkg;

    // State register codes (kept as plain vectors for legacy tooling).
    typedef logic [2:0] state_e;
    localparam state_e S_IDLE   = 3'd0;
    localparam state_e S_FETCH  = 3'd1;
    localparam state_e S_DECODE = 3'd2;
    localparam state_e S_EXEC   = 3'd3;
    localparam state_e S_MEM    = 3'd4;
    localparam state_e S_WB     = 3'd5;
    localparam state_e S_TRAP   = 3'd6;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] RES_ALU = 2'd0;
    localparam logic [1:0] RES_MEM = 2'd1;
    localparam logic [1:0] RES_PC4 = 2'd2;
    localparam logic [1:0] RES_IMM = 2'd3;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_TARGET = 2'd1;
    localparam logic [1:0] PC_ALU    = 2'd2;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_IMEM_TO = 2'd2;
    localparam logic [1:0] CAUSE_DMEM_TO = 2'd3;

    // SUB exists only for register-register ops (bit 30 of an OP-IMM add is
    // part of the immediate); SRA/SRAI are selected by bit 30 for both.
    function automatic alu_op_e alu_decode(input logic [2:0] funct3,
                                           input logic       funct7_5,
                                           input logic       is_op);
        alu_op_e op;
        case (funct3)
            3'b000:  op = (is_op && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = funct7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic logic opcode_legal(input logic [6:0] opc);
        return (opc == OPC_LOAD) || (opc == OPC_OP_IMM) || (opc == OPC_STORE) ||
               (opc == OPC_OP)   || (opc == OPC_LUI)    || (opc == OPC_BRANCH) ||
               (opc == OPC_JALR) || (opc == OPC_JAL);
    endfunction

endpackage

// File: rtl/cu_mem_if.sv
// Memory-side handshake bundle of the control unit.
//   imem_req / imem_ready / instr            : instruction fetch
//   mem_req / mem_write / datamem_control /
//   dmem_ready                               : data access
// master = control unit, slave = memory subsystem.
interface cu_mem_if;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] instr;
    logic        mem_req;
    logic        mem_write;
    logic [2:0]  datamem_control;
    logic        dmem_ready;

    modport master (
        output imem_req, mem_req, mem_write, datamem_control,
        input  imem_ready, instr, dmem_ready
    );

    modport slave (
        input  imem_req, mem_req, mem_write, datamem_control,
        output imem_ready, instr, dmem_ready
    );
endinterface

// File: rtl/cu_branch_eval.sv
// Branch condition evaluation from funct3 and the ALU compare flags.
//   funct3               in   branch type
//   alu_zero/lt/ltu      in   flags of rs1 - rs2
//   taken                out  branch condition holds
//   illegal              out  funct3 010/011 (no such branch)
module cu_branch_eval (
    input  logic [2:0] funct3,
    input  logic       alu_zero,
    input  logic       alu_lt,
    input  logic       alu_ltu,
    output logic       taken,
    output logic       illegal
);
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            3'b000:  taken = alu_zero;
            3'b001:  taken = !alu_zero;
            3'b100:  taken = alu_lt;
            3'b101:  taken = !alu_lt;
            3'b110:  taken = alu_ltu;
            3'b111:  taken = !alu_ltu;
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM. Sequences fetch/decode/execute/memory/
// writeback against ready-handshaked instruction and data memories and
// drives the datapath selects. A watchdog traps on memory stalls.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   mem (cu_mem_if.master)          instruction/data memory handshakes
//   alu_zero, alu_lt, alu_ltu       ALU flags, meaningful in EXEC
//   alu_control, alu_src, imm_src,
//   result_src, reg_write, pc_we,
//   pc_src                          datapath controls
//   trap, trap_cause                sticky trap flag and reason
//   cycle_cnt, instret_cnt          only with CU_PERF_CNT_EN defined
// Build option: CU_PERF_CNT_EN adds free-running performance counters.
//
// state  | meaning
// IDLE   | post-reset, one cycle, all outputs low
// FETCH  | imem_req high, waiting for imem_ready, IR loads on ready
// DECODE | legality check of IR
// EXEC   | ALU / branch / jump / LUI complete here; load/store form address
// MEM    | data access held stable until dmem_ready
// WB     | load data written to the register file
// TRAP   | absorbing; only trap/trap_cause driven
module multicycle_control_unit
    import cu_pkg::*;
#(
    parameter int ALUCTRL_W   = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cu_mem_if.master             mem,
    input  logic                 alu_zero,
    input  logic                 alu_lt,
    input  logic                 alu_ltu,
    output logic [ALUCTRL_W-1:0] alu_control,
    output logic                 alu_src,
    output logic [2:0]           imm_src,
    output logic [1:0]           result_src,
    output logic                 reg_write,
    output logic                 pc_we,
    output logic [1:0]           pc_src,
    output logic                 trap,
    output logic [1:0]           trap_cause
`ifdef CU_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]     cycle_cnt,
    output logic [CNT_W-1:0]     instret_cnt
`endif
);
    localparam int TMR_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_e           state_q, state_d;
    logic [6:0]       ir_opcode;
    logic [2:0]       ir_funct3;
    logic             ir_funct7_5;
    logic [TMR_W-1:0] tmr_q;
    logic             trap_q;
    logic [1:0]       cause_q, cause_d;
    logic             br_taken, br_illegal;
    logic             waiting, wdog_hit, decode_illegal, is_store, is_mem_op;
    alu_op_e          alu_op;
    logic             unused_instr;

    // Only opcode, funct3 and bit 30 steer control; the rest is datapath's.
    assign unused_instr = ^{mem.instr[31], mem.instr[29:15], mem.instr[11:7]};

    cu_branch_eval u_branch_eval (
        .funct3   (ir_funct3),
        .alu_zero (alu_zero),
        .alu_lt   (alu_lt),
        .alu_ltu  (alu_ltu),
        .taken    (br_taken),
        .illegal  (br_illegal)
    );

    assign is_store       = (ir_opcode == OPC_STORE);
    assign is_mem_op      = is_store || (ir_opcode == OPC_LOAD);
    assign decode_illegal = !opcode_legal(ir_opcode) ||
                            ((ir_opcode == OPC_BRANCH) && br_illegal);
    assign waiting        = ((state_q == S_FETCH) && !mem.imem_ready) ||
                            ((state_q == S_MEM)   && !mem.dmem_ready);
    // Timer is loaded with limit-1 on entry, so reaching zero while still
    // waiting marks the MEM_TIMEOUT-th stalled cycle. A ready in that cycle
    // takes priority in the next-state logic.
    assign wdog_hit       = (MEM_TIMEOUT != 0) && waiting && (tmr_q == '0);

    always_comb begin
        state_d = state_q;
        cause_d = CAUSE_NONE;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                if (mem.imem_ready) begin
                    state_d = S_DECODE;
                end else if (wdog_hit) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_IMEM_TO;
                end
            end
            S_DECODE: begin
                if (decode_illegal) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC:   state_d = is_mem_op ? S_MEM : S_FETCH;
            S_MEM: begin
                if (mem.dmem_ready) begin
                    state_d = is_store ? S_FETCH : S_WB;
                end else if (wdog_hit) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_DMEM_TO;
                end
            end
            S_WB:     state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ir_opcode   <= '0;
            ir_funct3   <= '0;
            ir_funct7_5 <= 1'b0;
            tmr_q       <= '0;
            trap_q      <= 1'b0;
            cause_q     <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            if ((state_q == S_FETCH) && mem.imem_ready) begin
                ir_opcode   <= mem.instr[6:0];
                ir_funct3   <= mem.instr[14:12];
                ir_funct7_5 <= mem.instr[30];
            end
            if (state_d != state_q) begin
                tmr_q <= TMR_LOAD;
            end else if (waiting && (tmr_q != '0)) begin
                tmr_q <= tmr_q - TMR_W'(1);
            end
            if ((state_d == S_TRAP) && (state_q != S_TRAP)) begin
                trap_q  <= 1'b1;
                cause_q <= cause_d;
            end
        end
    end

    always_comb begin
        mem.imem_req        = 1'b0;
        mem.mem_req         = 1'b0;
        mem.mem_write       = 1'b0;
        mem.datamem_control = 3'd0;
        alu_op              = ALU_ADD;
        alu_src             = 1'b0;
        imm_src             = IMM_I;
        result_src          = RES_ALU;
        reg_write           = 1'b0;
        pc_we               = 1'b0;
        pc_src              = PC_PLUS4;
        case (state_q)
            S_FETCH: mem.imem_req = 1'b1;
            S_EXEC: begin
                case (ir_opcode)
                    OPC_OP: begin
                        alu_op    = alu_decode(ir_funct3, ir_funct7_5, 1'b1);
                        reg_write = 1'b1;
                        pc_we     = 1'b1;
                    end
                    OPC_OP_IMM: begin
                        alu_op    = alu_decode(ir_funct3, ir_funct7_5, 1'b0);
                        alu_src   = 1'b1;
                        reg_write = 1'b1;
                        pc_we     = 1'b1;
                    end
                    OPC_BRANCH: begin
                        alu_op  = ALU_SUB;
                        imm_src = IMM_B;
                        pc_we   = 1'b1;
                        pc_src  = br_taken ? PC_TARGET : PC_PLUS4;
                    end
                    OPC_JAL: begin
                        imm_src    = IMM_J;
                        result_src = RES_PC4;
                        reg_write  = 1'b1;
                        pc_we      = 1'b1;
                        pc_src     = PC_TARGET;
                    end
                    OPC_JALR: begin
                        alu_src    = 1'b1;
                        result_src = RES_PC4;
                        reg_write  = 1'b1;
                        pc_we      = 1'b1;
                        pc_src     = PC_ALU;
                    end
                    OPC_LUI: begin
                        imm_src    = IMM_U;
                        result_src = RES_IMM;
                        reg_write  = 1'b1;
                        pc_we      = 1'b1;
                    end
                    OPC_LOAD:  alu_src = 1'b1;
                    OPC_STORE: begin
                        alu_src = 1'b1;
                        imm_src = IMM_S;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                // Address selects stay as in EXEC so the access is stable.
                mem.mem_req         = 1'b1;
                mem.mem_write       = is_store;
                mem.datamem_control = ir_funct3;
                alu_src             = 1'b1;
                imm_src             = is_store ? IMM_S : IMM_I;
                pc_we               = is_store && mem.dmem_ready;
            end
            S_WB: begin
                // Width/sign select kept for the load extender.
                mem.datamem_control = ir_funct3;
                result_src          = RES_MEM;
                reg_write           = 1'b1;
                pc_we               = 1'b1;
            end
            default: ;
        endcase
    end

    assign alu_control = ALUCTRL_W'(alu_op);
    assign trap        = trap_q;
    assign trap_cause  = cause_q;

`ifdef CU_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if ((state_q != S_IDLE) && (state_q != S_TRAP)) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
            if (pc_we) begin
                instret_cnt <= instret_cnt + CNT_W'(1);
            end
        end
    end
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;
    import cu_pkg::*;

    localparam logic [6:0] T_LOAD = 7'b0000011, T_OPI = 7'b0010011, T_STORE = 7'b0100011,
                           T_OP = 7'b0110011, T_LUI = 7'b0110111, T_BR = 7'b1100011,
                           T_JALR = 7'b1100111, T_JAL = 7'b1101111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cu_mem_if bus ();
    logic       alu_zero, alu_lt, alu_ltu;
    logic [3:0] alu_control;
    logic       alu_src, reg_write, pc_we, trap;
    logic [2:0] imm_src;
    logic [1:0] result_src, pc_src, trap_cause;
`ifdef CU_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    multicycle_control_unit #(.ALUCTRL_W(4), .MEM_TIMEOUT(15), .CNT_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem         (bus),
        .alu_zero    (alu_zero),
        .alu_lt      (alu_lt),
        .alu_ltu     (alu_ltu),
        .alu_control (alu_control),
        .alu_src     (alu_src),
        .imm_src     (imm_src),
        .result_src  (result_src),
        .reg_write   (reg_write),
        .pc_we       (pc_we),
        .pc_src      (pc_src),
        .trap        (trap),
        .trap_cause  (trap_cause)
`ifdef CU_PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       reg_write, pc_we;
        logic [1:0] pc_src, result_src;
        logic [3:0] alu;
        logic       alu_src;
        logic [2:0] imm_src;
        logic       chk_alu, mem, store;
    } exp_t;

    logic [2:0] br_f3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk(tag, {12'b0, bus.imem_req, bus.mem_req, bus.mem_write, bus.datamem_control,
                  alu_control, alu_src, imm_src, result_src, reg_write, pc_we, pc_src}, 32'd0);
    endtask

    // Expected EXEC-cycle behaviour of one instruction, derived from the
    // instruction class and the actual operand values a (rs1) and b (rs2).
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [6:0] opc;
        logic [2:0] f3;
        logic taken;
        logic [3:0] by_f3 [8];
        e = '0;
        opc = ins[6:0];
        f3 = ins[14:12];
        by_f3 = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        case (f3)
            3'd0: taken = (a == b);
            3'd1: taken = (a != b);
            3'd4: taken = ($signed(a) < $signed(b));
            3'd5: taken = ($signed(a) >= $signed(b));
            3'd6: taken = (a < b);
            default: taken = (a >= b);
        endcase
        case (opc)
            T_OP, T_OPI: begin
                e.reg_write = 1; e.pc_we = 1; e.chk_alu = 1;
                e.alu_src = (opc == T_OPI);
                e.alu = by_f3[f3];
                if (f3 == 3'd0 && opc == T_OP && ins[30]) e.alu = ALU_SUB;
                if (f3 == 3'd5 && ins[30]) e.alu = ALU_SRA;
            end
            T_BR: begin
                e.pc_we = 1; e.chk_alu = 1; e.alu = ALU_SUB; e.imm_src = 3'd2;
                e.pc_src = taken ? 2'd1 : 2'd0;
            end
            T_JAL:  begin e.reg_write = 1; e.pc_we = 1; e.result_src = 2; e.pc_src = 1; e.imm_src = 4; end
            T_JALR: begin e.reg_write = 1; e.pc_we = 1; e.result_src = 2; e.pc_src = 2; e.imm_src = 0; end
            T_LUI:  begin e.reg_write = 1; e.pc_we = 1; e.result_src = 3; e.pc_src = 0; e.imm_src = 3; end
            T_LOAD: begin e.chk_alu = 1; e.alu = ALU_ADD; e.alu_src = 1; e.mem = 1; end
            default: begin e.chk_alu = 1; e.alu = ALU_ADD; e.alu_src = 1; e.imm_src = 1; e.mem = 1; e.store = 1; end
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 7))
            0: w[6:0] = T_OP;
            1: w[6:0] = T_OPI;
            2: begin w[6:0] = T_BR; w[14:12] = br_f3[$urandom_range(0, 5)]; end
            3: w[6:0] = T_JAL;
            4: begin w[6:0] = T_JALR; w[14:12] = 3'd0; end
            5: w[6:0] = T_LUI;
            6: begin w[6:0] = T_LOAD; w[14:12] = ld_f3[$urandom_range(0, 4)]; end
            default: begin w[6:0] = T_STORE; w[14:12] = 3'($urandom_range(0, 2)); end
        endcase
        return w;
    endfunction

    // Starts at a negedge with the DUT in FETCH; ends #1 after the negedge
    // where the DUT is expected back in FETCH.
    task automatic run_instr(input logic [31:0] ins, input int idly, input int ddly,
                             input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e = model(ins, a, b);
        for (int i = 0; i <= idly; i++) begin
            bus.imem_ready = (i == idly);
            bus.instr = (i == idly) ? ins : $urandom;
            {alu_zero, alu_lt, alu_ltu} = 3'($urandom);
            #1;
            chk("fetch_req", bus.imem_req, 1);
            chk("fetch_no_trap", trap, 0);
            chk("fetch_ctrl", {reg_write, pc_we, bus.mem_req}, 0);
            @(negedge clk);
        end
        bus.imem_ready = 1'b0;
        bus.instr = $urandom;
        #1;
        chk("decode_ctrl", {bus.imem_req, bus.mem_req, reg_write, pc_we}, 0);
        @(negedge clk);
        alu_zero = (a == b);
        alu_lt   = ($signed(a) < $signed(b));
        alu_ltu  = (a < b);
        #1;
        chk("exec_reg_write", reg_write, e.reg_write);
        chk("exec_pc_we", pc_we, e.pc_we);
        chk("exec_imem_req", {bus.imem_req, bus.mem_req}, 0);
        chk("exec_imm_src", imm_src, e.imm_src);
        if (e.pc_we) chk("exec_pc_src", pc_src, e.pc_src);
        if (e.reg_write) chk("exec_result_src", result_src, e.result_src);
        if (e.chk_alu) begin
            chk("exec_alu_control", alu_control, e.alu);
            chk("exec_alu_src", alu_src, e.alu_src);
        end
        @(negedge clk);
        if (e.mem) begin
            for (int i = 0; i <= ddly; i++) begin
                bus.dmem_ready = (i == ddly);
                {alu_zero, alu_lt, alu_ltu} = 3'($urandom);
                #1;
                chk("mem_req", bus.mem_req, 1);
                chk("mem_write", bus.mem_write, e.store);
                chk("mem_funct3", bus.datamem_control, ins[14:12]);
                chk("mem_pc_we", pc_we, e.store && (i == ddly));
                chk("mem_reg_write", reg_write, 0);
                if (pc_we) chk("mem_pc_src", pc_src, 0);
                @(negedge clk);
            end
            bus.dmem_ready = 1'b0;
            if (!e.store) begin
                #1;
                chk("wb_result_src", result_src, 1);
                chk("wb_reg_write", reg_write, 1);
                chk("wb_pc_we", pc_we, 1);
                chk("wb_pc_src", pc_src, 0);
                chk("wb_mem_req", bus.mem_req, 0);
                @(negedge clk);
            end
        end
        #1;
        chk("next_fetch", bus.imem_req, 1);
    endtask

    // Ends at the negedge of the first FETCH cycle after reset.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        #1;
        chk_quiet("reset_outputs");
        chk("reset_trap", {trap, trap_cause}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_quiet("idle_outputs");
        @(negedge clk);
    endtask

    task automatic fde(input logic [31:0] ins);
        bus.imem_ready = 1'b1;
        bus.instr = ins;
        @(negedge clk);
        bus.imem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic expect_trap(input string tag, input logic [1:0] cause);
        for (int i = 0; i < 3; i++) begin
            bus.imem_ready = 1'($urandom);
            bus.dmem_ready = 1'($urandom);
            #1;
            chk({tag, "_trap"}, trap, 1);
            chk({tag, "_cause"}, trap_cause, cause);
            chk_quiet({tag, "_quiet"});
            @(negedge clk);
        end
    endtask

    initial begin
        logic [31:0] a, b;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        bus.instr = '0;
        alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0;
        do_reset();

        // ADD x3,x1,x2
        run_instr(32'h002081B3, 0, 0, 32'd7, 32'd9);
        // BLT taken, then not taken
        run_instr(32'h0020C063, 0, 0, 32'hFFFF_FFFF, 32'd1);
        run_instr(32'h0020C063, 1, 0, 32'd5, 32'd1);
        // LW with dmem_ready low for 3 cycles
        run_instr(32'h0000A283, 0, 3, 32'd0, 32'd0);
        // imem ready exactly on the 15th stalled cycle: no trap
        run_instr(32'h002081B3, 14, 0, 32'd1, 32'd2);

        for (int n = 0; n < 60; n++) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            run_instr(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3), a, b);
        end

        // Reset in the middle of a stalled load
        @(negedge clk);
        fde(32'h0000A283);
        #1;
        chk("midmem_req", bus.mem_req, 1);
        do_reset();
        #1;
        chk("after_reset_fetch", bus.imem_req, 1);

        // Branch with funct3 = 010
        @(negedge clk);
        fde(32'h0020A063);
        expect_trap("illegal_branch", 2'd1);
        do_reset();

        // Unsupported opcode (AUIPC)
        fde(32'h00000097);
        expect_trap("illegal_opcode", 2'd1);
        do_reset();

        // imem stuck not ready
        for (int i = 0; i < 15; i++) begin
            #1;
            chk("imem_stall_req", bus.imem_req, 1);
            chk("imem_stall_trap", trap, 0);
            @(negedge clk);
        end
        expect_trap("imem_timeout", 2'd2);
        do_reset();

        // dmem stuck not ready on a store
        fde(32'h0020A023);
        for (int i = 0; i < 15; i++) begin
            #1;
            chk("dmem_stall_req", bus.mem_req, 1);
            chk("dmem_stall_trap", trap, 0);
            @(negedge clk);
        end
        expect_trap("dmem_timeout", 2'd3);
        do_reset();

`ifdef CU_PERF_CNT_EN
        for (int n = 0; n < 10; n++) run_instr(32'h002081B3, 0, 0, 32'd1, 32'd2);
        bus.imem_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("perf_instret", instret_cnt, 32'd10);
        chk("perf_cycles", cycle_cnt, 32'd31);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
